pcm_frame_buffer: RTL and testbench
===================================

// Module: pcm_frame_buffer
// PURPOSE
//  Ping-pong frame buffer between the codec I2S receiver and the FFT stage.
//  Collects PCM_WIDTH-bit samples arriving at the audio rate into FFT_LEN-deep banks.
//  Streams each completed frame to the FFT input over a valid/ready handshake with sop/eop framing.
//  One bank fills while the other drains; samples are dropped and counted only when both banks are full.
// PARAMETERS
//  PCM_WIDTH  16    sample width, two's complement
//  FFT_LEN    1024  samples per frame; power of two, >= 4
// PORTS
//  clk_50m         in   1          system clock
//  rst             in   1          asynchronous reset, active-high
//  pcm_in_valid    in   1          1-cycle strobe, sample present
//  pcm_in_sample   in   PCM_WIDTH  sample, signed
//  fft_out_valid   out  1          output beat valid
//  fft_out_ready   in   1          FFT stage accepts beat
//  fft_out_data    out  PCM_WIDTH  sample, in arrival order within frame
//  fft_out_sop     out  1          beat 0 of frame
//  fft_out_eop     out  1          beat FFT_LEN-1 of frame
//  sample_drop     out  1          1-cycle pulse per dropped input sample
//  drop_cnt        out  16         dropped-sample count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, rst=1):
//   - All outputs are 0.
//   - Both bank full flags are cleared, wr_bank=rd_bank=0, wr_idx=0, read FSM=IDLE.
//   - Any partial frame is discarded.
//  Write side:
//   - A sample is accepted when pcm_in_valid=1 and the bank at wr_bank is free.
//   - A bank counts as free if its full flag is 0, or it is being released in this cycle.
//   - Accepted sample is written to bank[wr_bank][wr_idx], then wr_idx increments.
//   - When the sample at wr_idx=FFT_LEN-1 is accepted: full[wr_bank] is set at that edge,
//     wr_bank toggles and wr_idx wraps to 0.
//   - If pcm_in_valid=1 and the bank is not free: sample discarded, sample_drop=1 for one cycle,
//     drop_cnt increments (holds at 16'hFFFF). wr_idx is unchanged.
//  Read FSM:
//   - IDLE: when full[rd_bank]=1, present RAM address 0 and go to STREAM.
//   - STREAM: RAM read latency is 1 cycle. An output register plus a one-entry skid buffer
//     sustain one beat per cycle while fft_out_ready=1.
//   - Read address advances only when the skid buffer has room.
//   - While valid=1 and ready=0, data/sop/eop are held stable.
//   - On the eop handshake (valid & ready & eop): full[rd_bank] is cleared (release), rd_bank
//     toggles, go to IDLE.
//   - Back-to-back full banks: the next frame's valid may follow after the IDLE/prime gap.
//  Latency:
//   - fft_out_valid rises 2 cycles after the edge that accepted the last sample of a frame,
//     provided the read FSM was IDLE.
//   - With ready held at 1, the frame occupies exactly FFT_LEN consecutive cycles.
//  Ordering: frames are emitted in fill order; samples within a frame in arrival order; no
//   duplication and no reordering under any backpressure pattern.
//  Simultaneous events:
//   - Release and a write into the same bank in one cycle: the write is accepted, no drop.
//   - Last-sample accept and eop of the other bank in one cycle are both honoured.
//  Output flags: sop/eop are valid only when fft_out_valid=1, and are 0 otherwise.
// TESTING
//  (FFT_LEN=8 unless stated)
//  1. ready=1; feed samples 0..7 -> valid rises 2 cycles after sample 7 is accepted;
//     data 0..7 on 8 consecutive beats; sop on beat 0, eop on beat 7; drop_cnt=0.
//  2. ready=1; feed 0..7 with ready forced 0 for 5 cycles starting at beat 3 -> data=3 held
//     for 5 cycles, then 4..7 follow; 8 beats total, no repeats.
//  3. ready=0; feed 0..18 -> sample_drop pulses 3 times (samples 16..18), drop_cnt=3;
//     then ready=1 -> two frames 0..7 and 8..15.
//  4. Both banks full, ready=1: pcm_in_valid coincides with the eop handshake of bank 0 ->
//     sample accepted into bank 0 at idx 0, no sample_drop.
//  5. Assert rst at beat 4 of a frame -> all outputs 0 while rst=1; after release, feed 100..107
//     -> one frame 100..107 with sop/eop correct, drop_cnt=0.
//  6. FFT_LEN=4, ready=0; feed 65545 samples -> drop_cnt saturates at 16'hFFFF and stays there
//     on further drops.

Source files
------------

// File: rtl/pcm_frame_buffer.sv
// pcm_frame_buffer
// Ping-pong frame buffer between the I2S receiver and the FFT stage.
// Two FFT_LEN-deep banks: one fills from the audio stream while the other
// drains to the FFT over valid/ready with sop/eop framing. Input samples are
// dropped (and counted) only when both banks hold complete, unreleased frames.
//
// Ports
//   clk_50m        system clock
//   rst            asynchronous reset, active-high
//   pcm_in_valid   1-cycle strobe, sample present
//   pcm_in_sample  signed PCM sample
//   fft_out_valid  output beat valid
//   fft_out_ready  FFT stage accepts beat
//   fft_out_data   sample, arrival order within the frame
//   fft_out_sop    first beat of a frame
//   fft_out_eop    last beat of a frame
//   sample_drop    1-cycle pulse per dropped input sample
//   drop_cnt       dropped-sample count, saturating at 16'hFFFF
module pcm_frame_buffer #(
    parameter int PCM_WIDTH = 16,
    parameter int FFT_LEN   = 1024
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic                 pcm_in_valid,
    input  logic [PCM_WIDTH-1:0] pcm_in_sample,
    output logic                 fft_out_valid,
    input  logic                 fft_out_ready,
    output logic [PCM_WIDTH-1:0] fft_out_data,
    output logic                 fft_out_sop,
    output logic                 fft_out_eop,
    output logic                 sample_drop,
    output logic [15:0]          drop_cnt
);

    localparam int            IW   = $clog2(FFT_LEN);
    localparam logic [IW-1:0] LAST = IW'(FFT_LEN - 1);
    localparam logic [IW:0]   DONE = (IW+1)'(FFT_LEN);

    typedef struct packed {
        logic [PCM_WIDTH-1:0] data;
        logic                 sop;
        logic                 eop;
    } beat_t;

    typedef enum logic {IDLE, STREAM} rd_state_t;

    // Bank b occupies addresses {b, idx}.
    logic [PCM_WIDTH-1:0] mem [2*FFT_LEN];

    logic [1:0]           full;
    logic                 wr_bank;
    logic [IW-1:0]        wr_idx;

    rd_state_t            state;
    logic                 rd_bank;
    logic [IW:0]          rd_cnt;     // reads issued for the current frame
    logic                 ram_vld;
    logic                 ram_sop;
    logic                 ram_eop;
    logic [PCM_WIDTH-1:0] ram_q;
    beat_t                out_r;
    logic                 out_vld;
    beat_t                skid;
    logic                 skid_vld;

    logic                 pop;
    logic                 rel;
    logic                 wr_free;
    logic                 accept;
    logic                 drop;
    logic                 wr_last;
    logic                 issue;
    logic [1:0]           inflight;
    beat_t                ram_beat;

    assign pop      = out_vld & fft_out_ready;
    assign rel      = pop & out_r.eop;
    // A bank being released this cycle may take a new sample at the same edge.
    assign wr_free  = !full[wr_bank] || (rel && (rd_bank == wr_bank));
    assign accept   = pcm_in_valid & wr_free;
    assign drop     = pcm_in_valid & !wr_free;
    assign wr_last  = accept && (wr_idx == LAST);

    // Beats already read or on their way out; at most two fit (output + skid).
    assign inflight = 2'(out_vld) + 2'(skid_vld) + 2'(ram_vld);
    // IDLE primes address 0 as soon as the bank is full so valid rises two
    // edges after the last sample lands.
    assign issue    = (state == IDLE) ? full[rd_bank]
                    : ((rd_cnt != DONE) && ((inflight < 2'd2) || pop));

    assign ram_beat = '{data: ram_q, sop: ram_sop, eop: ram_eop};

    assign fft_out_valid = out_vld;
    assign fft_out_data  = out_r.data;
    assign fft_out_sop   = out_r.sop;
    assign fft_out_eop   = out_r.eop;

    // Sample storage, 1-cycle read latency.
    always_ff @(posedge clk_50m) begin
        if (accept)
            mem[{wr_bank, wr_idx}] <= pcm_in_sample;
        if (issue)
            ram_q <= mem[{rd_bank, rd_cnt[IW-1:0]}];
    end

    // Write side, bank full flags and drop accounting.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            full        <= '0;
            wr_bank     <= 1'b0;
            wr_idx      <= '0;
            sample_drop <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_last && (wr_bank == 1'(b)))
                    full[b] <= 1'b1;
                else if (rel && (rd_bank == 1'(b)))
                    full[b] <= 1'b0;
            end
            if (accept) begin
                wr_idx <= wr_idx + 1'b1;   // wraps to 0 after LAST
                if (wr_last)
                    wr_bank <= ~wr_bank;
            end
            sample_drop <= drop;
            if (drop && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Read FSM, RAM output stage, output register and skid buffer.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_bank  <= 1'b0;
            rd_cnt   <= '0;
            ram_vld  <= 1'b0;
            ram_sop  <= 1'b0;
            ram_eop  <= 1'b0;
            out_r    <= '0;
            out_vld  <= 1'b0;
            skid     <= '0;
            skid_vld <= 1'b0;
        end else begin
            ram_vld <= issue;
            ram_sop <= issue && (rd_cnt == '0);
            ram_eop <= issue && (rd_cnt[IW-1:0] == LAST);
            if (issue)
                rd_cnt <= rd_cnt + 1'b1;

            case (state)
                IDLE:   if (issue) state <= STREAM;
                STREAM: if (rel) begin
                    state   <= IDLE;
                    rd_bank <= ~rd_bank;
                    rd_cnt  <= '0;
                end
                default: state <= IDLE;
            endcase

            // ram_sop/ram_eop are 0 whenever ram_vld is 0, so the flags
            // drop together with valid.
            if (!out_vld || pop) begin
                if (skid_vld) begin
                    out_r    <= skid;
                    out_vld  <= 1'b1;
                    skid     <= ram_beat;
                    skid_vld <= ram_vld;
                end else begin
                    out_r    <= ram_beat;
                    out_vld  <= ram_vld;
                end
            end else if (ram_vld) begin
                skid     <= ram_beat;
                skid_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcm_frame_buffer.sv
// Bench for pcm_frame_buffer (FFT_LEN=8). The reference model tracks the
// buffer as a list of completed, unreleased frames plus a partial frame:
// a sample is dropped exactly when two complete frames are still held and
// neither is released on that edge.
module tb_pcm_frame_buffer;

    localparam int PW = 16;
    localparam int FL = 8;

    logic          clk_50m = 1'b0;
    logic          rst;
    logic          pcm_in_valid;
    logic [PW-1:0] pcm_in_sample;
    logic          fft_out_valid;
    logic          fft_out_ready;
    logic [PW-1:0] fft_out_data;
    logic          fft_out_sop;
    logic          fft_out_eop;
    logic          sample_drop;
    logic [15:0]   drop_cnt;

    always #5 clk_50m = ~clk_50m;

    pcm_frame_buffer #(.PCM_WIDTH(PW), .FFT_LEN(FL)) dut (
        .clk_50m       (clk_50m),
        .rst           (rst),
        .pcm_in_valid  (pcm_in_valid),
        .pcm_in_sample (pcm_in_sample),
        .fft_out_valid (fft_out_valid),
        .fft_out_ready (fft_out_ready),
        .fft_out_data  (fft_out_data),
        .fft_out_sop   (fft_out_sop),
        .fft_out_eop   (fft_out_eop),
        .sample_drop   (sample_drop),
        .drop_cnt      (drop_cnt)
    );

    // Reference model state
    logic [15:0] m_frames[$];   // samples of complete, unreleased frames
    logic [15:0] m_part[$];     // partial frame being filled
    int          m_pend;        // complete frames not yet released
    int          m_beat;        // beat index within the head frame
    int          m_hs;          // handshakes seen
    int          coinc_hits;    // release and write on the same edge with both banks full
    logic        m_exp_drop;
    logic [15:0] m_drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_frames.delete();
        m_part.delete();
        m_pend     = 0;
        m_beat     = 0;
        m_exp_drop = 1'b0;
        m_drop_cnt = '0;
    endtask

    // Called at a negedge: drive inputs for the next edge, check the
    // presented beat against the model, advance the model, cross the edge.
    task automatic step(input logic iv, input logic [15:0] s, input logic rdy);
        logic rel;
        int   pend0;
        rel   = 1'b0;
        pend0 = m_pend;
        pcm_in_valid  = iv;
        pcm_in_sample = s;
        fft_out_ready = rdy;
        if (fft_out_valid) begin
            if (m_pend == 0) begin
                chk("spurious_valid", fft_out_valid, 0);
            end else begin
                chk("data", fft_out_data, m_frames[0]);
                chk("sop", fft_out_sop, m_beat == 0);
                chk("eop", fft_out_eop, m_beat == FL - 1);
                if (rdy) begin
                    void'(m_frames.pop_front());
                    m_hs++;
                    m_beat++;
                    if (m_beat == FL) begin
                        m_beat = 0;
                        m_pend--;
                        rel = 1'b1;
                    end
                end
            end
        end else begin
            chk("sop_idle", fft_out_sop, 0);
            chk("eop_idle", fft_out_eop, 0);
        end
        m_exp_drop = 1'b0;
        if (iv) begin
            if (m_pend == 2) begin
                m_exp_drop = 1'b1;
                if (m_drop_cnt != 16'hFFFF) m_drop_cnt++;
            end else begin
                if (rel && pend0 == 2) coinc_hits++;
                m_part.push_back(s);
                if (m_part.size() == FL) begin
                    foreach (m_part[k]) m_frames.push_back(m_part[k]);
                    m_part.delete();
                    m_pend++;
                end
            end
        end
        @(negedge clk_50m);
        chk("sample_drop", sample_drop, m_exp_drop);
        chk("drop_cnt", drop_cnt, m_drop_cnt);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (m_pend > 0 && n < max_cyc) begin
            step(1'b0, 16'h0, 1'b1);
            n++;
        end
        chk("drain_pending", m_pend, 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, fft_out_valid, 0);
        chk({tag, "_data"},  fft_out_data,  0);
        chk({tag, "_sop"},   fft_out_sop,   0);
        chk({tag, "_eop"},   fft_out_eop,   0);
        chk({tag, "_drop"},  sample_drop,   0);
        chk({tag, "_cnt"},   drop_cnt,      0);
    endtask

    task automatic do_reset();
        pcm_in_valid  = 1'b0;
        pcm_in_sample = '0;
        fft_out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk_50m);
        @(negedge clk_50m);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        int hs0;
        int run;
        int guard;
        logic iv;

        m_hs = 0;
        coinc_hits = 0;
        model_reset();
        rst = 1'b1;
        pcm_in_valid  = 1'b0;
        pcm_in_sample = '0;
        fft_out_ready = 1'b0;
        @(negedge clk_50m);
        @(negedge clk_50m);
        chk_outputs_zero("reset");
        rst = 1'b0;

        // 1: single frame, latency and back-to-back beats
        for (int i = 0; i < FL; i++) step(1'b1, 16'(i), 1'b1);
        chk("t1_lat0", fft_out_valid, 0);
        step(1'b0, 16'h0, 1'b1);
        chk("t1_lat1", fft_out_valid, 0);
        step(1'b0, 16'h0, 1'b1);
        chk("t1_lat2", fft_out_valid, 1);
        run = 0;
        for (int k = 0; k < FL; k++) begin
            run += int'(fft_out_valid);
            step(1'b0, 16'h0, 1'b1);
        end
        chk("t1_run", run, FL);
        chk("t1_after", fft_out_valid, 0);
        chk("t1_pend", m_pend, 0);

        // 2: ready low for 5 cycles starting at beat 3
        hs0 = m_hs;
        for (int i = 0; i < FL; i++) step(1'b1, 16'(i), 1'b1);
        guard = 0;
        while (!(fft_out_valid && m_beat == 3) && guard < 20) begin
            step(1'b0, 16'h0, 1'b1);
            guard++;
        end
        chk("t2_reach_beat3", fft_out_valid, 1);
        for (int k = 0; k < 5; k++) step(1'b0, 16'h0, 1'b0);
        chk("t2_held_data", fft_out_data, 3);
        drain(30);
        chk("t2_beats", m_hs - hs0, FL);

        // 3: overflow with ready low, then two frames drain
        for (int i = 0; i < 19; i++) step(1'b1, 16'(i), 1'b0);
        chk("t3_drop_cnt", drop_cnt, 3);
        hs0 = m_hs;
        drain(60);
        chk("t3_beats", m_hs - hs0, 2 * FL);

        // 4: write coincides with eop release of the bank it targets
        for (int i = 0; i < 2 * FL; i++) step(1'b1, 16'h200 + 16'(i), 1'b0);
        coinc_hits = 0;
        guard = 0;
        iv = 1'b0;
        while (!iv && guard < 40) begin
            iv = fft_out_valid && (m_beat == FL - 1) && (m_pend == 2);
            step(iv, 16'h4000, 1'b1);
            guard++;
        end
        chk("t4_coinc", coinc_hits, 1);
        chk("t4_drop_cnt", drop_cnt, 3);
        for (int i = 1; i < FL; i++) step(1'b1, 16'h4000 + 16'(i), 1'b1);
        drain(60);

        // 5: reset mid-frame, then a clean frame
        for (int i = 0; i < FL; i++) step(1'b1, 16'(50 + i), 1'b1);
        guard = 0;
        while (!(fft_out_valid && m_beat == 4) && guard < 20) begin
            step(1'b0, 16'h0, 1'b1);
            guard++;
        end
        chk("t5_reach_beat4", fft_out_valid, 1);
        pcm_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_outputs_zero("t5_rst_async");
        @(negedge clk_50m);
        chk_outputs_zero("t5_rst_held");
        model_reset();
        rst = 1'b0;
        hs0 = m_hs;
        for (int i = 0; i < FL; i++) step(1'b1, 16'(100 + i), 1'b1);
        drain(30);
        chk("t5_beats", m_hs - hs0, FL);
        chk("t5_drop_cnt", drop_cnt, 0);

        // 6: drop counter saturation
        for (int n = 0; n < 2 * FL + 65537; n++) step(1'b1, 16'(n), 1'b0);
        chk("t6_sat", drop_cnt, 16'hFFFF);
        for (int n = 0; n < 4; n++) step(1'b1, 16'h1234, 1'b0);
        chk("t6_sat_hold", drop_cnt, 16'hFFFF);
        drain(60);

        // 7: random traffic and backpressure
        do_reset();
        for (int n = 0; n < 3000; n++)
            step(($urandom % 3) != 0, 16'($urandom), ($urandom % 4) != 0);
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
